// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared constants and helpers for the snake-display VGA tile engine.
//   Holds the default 640x480@60 timing (25 MHz pixel rate derived from the
//   100 MHz board clock), the default colour depth and the helper that turns
//   the four per-axis timing fields into a total period.
package vga_pkg;

  // Default 640x480@60 horizontal timing, in pixels.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default 640x480@60 vertical timing, in lines.
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Default bits per colour channel.
  localparam int DEF_COLOR_W  = 4;

  // Total period of one axis: active + front porch + sync + back porch.
  function automatic int vga_total(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing
//   Pixel-enable divider plus horizontal/vertical raster counters.
//   The counters only move on pe, so a "slot" is PIX_DIV clk cycles long and
//   pe marks its last cycle. All outputs describe the slot currently running.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   pe        out  pixel enable, high in the last clk of each slot
//   h, v      out  current column / line counters
//   vis       out  current slot lies in the visible region
//   hs_act    out  current slot lies inside the horizontal sync pulse
//   vs_act    out  current line lies inside the vertical sync pulse
//   frame_end out  pe of the very last slot of the frame
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIX_DIV  = 4,
  parameter int HW       = $clog2(vga_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP)),
  parameter int VW       = $clog2(vga_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP))
)(
  input  logic          clk,
  input  logic          rst_n,
  output logic          pe,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          vis,
  output logic          hs_act,
  output logic          vs_act,
  output logic          frame_end
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW      = $clog2(PIX_DIV);

  logic [DW-1:0] div_r;
  logic [HW-1:0] h_r;
  logic [VW-1:0] v_r;
  logic          pe_s;
  logic          h_last_s;
  logic          v_last_s;

  // Wrap is by compare against the period, so the counters never overflow.
  assign pe_s     = (div_r == DW'(PIX_DIV - 1));
  assign h_last_s = (int'(h_r) == H_TOTAL - 1);
  assign v_last_s = (int'(v_r) == V_TOTAL - 1);

  // Clock divider: counts 0..PIX_DIV-1, wrapping on pe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
    end else if (pe_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + 1'b1;
    end
  end

  // Raster counters: h steps every pe, v steps when h wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_r <= '0;
      v_r <= '0;
    end else if (pe_s) begin
      if (h_last_s) begin
        h_r <= '0;
        if (v_last_s) begin
          v_r <= '0;
        end else begin
          v_r <= v_r + 1'b1;
        end
      end else begin
        h_r <= h_r + 1'b1;
      end
    end
  end

  assign pe        = pe_s;
  assign h         = h_r;
  assign v         = v_r;
  assign vis       = (int'(h_r) < H_ACTIVE) && (int'(v_r) < V_ACTIVE);
  assign hs_act    = (int'(h_r) >= H_ACTIVE + H_FP) &&
                     (int'(h_r) <  H_ACTIVE + H_FP + H_SYNC);
  assign vs_act    = (int'(v_r) >= V_ACTIVE + V_FP) &&
                     (int'(v_r) <  V_ACTIVE + V_FP + V_SYNC);
  assign frame_end = pe_s && h_last_s && v_last_s;

endmodule

// File: rtl/vga_tile_engine.sv
// vga_tile_engine
//   VGA timing generator and tile-map renderer for the snake display.
//   Stage 1 (end of slot k)  : tile-map address, in-tile coordinates and flags.
//   Stage 2 (end of slot k+1): tile type from the map RAM -> texture ROM request.
//   Stage 3 (end of slot k+2): texel/border/black colour plus HSYNC/VSYNC.
//   Colour and sync travel through the same three stages and stay aligned.
//   External RAM/ROM must answer within PIX_DIV-1 clk of an address change.
// Ports:
//   clk_100mhz    in   system clock
//   RSTN          in   asynchronous active-low reset
//   map_addr      out  {tile_col, tile_row} to the game-state RAM
//   map_type      in   tile type returned by the map RAM
//   tex_type      out  tile type to the texture ROM
//   tex_x, tex_y  out  texel column / row within the tile
//   tex_pixel     in   {R,G,B} texel from the texture ROM
//   border_color  in   {R,G,B} used for visible pixels outside the map
//   Red/Green/Blue out pixel colour
//   HSYNC, VSYNC  out  sync outputs with configurable polarity
//   frame_start   out  one-clk strobe in the cycle output pixel (0,0) appears
module vga_tile_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int PIX_DIV   = 4,
  parameter int TILE_LOG2 = 5,
  parameter int MAP_COLS  = 20,
  parameter int MAP_ROWS  = 15,
  parameter int TYPE_W    = 4,
  parameter int COLOR_W   = DEF_COLOR_W
)(
  input  logic                                         clk_100mhz,
  input  logic                                         RSTN,
  output logic [$clog2(MAP_COLS)+$clog2(MAP_ROWS)-1:0] map_addr,
  input  logic [TYPE_W-1:0]                            map_type,
  output logic [TYPE_W-1:0]                            tex_type,
  output logic [TILE_LOG2-1:0]                         tex_x,
  output logic [TILE_LOG2-1:0]                         tex_y,
  input  logic [3*COLOR_W-1:0]                         tex_pixel,
  input  logic [3*COLOR_W-1:0]                         border_color,
  output logic [COLOR_W-1:0]                           Red,
  output logic [COLOR_W-1:0]                           Green,
  output logic [COLOR_W-1:0]                           Blue,
  output logic                                         HSYNC,
  output logic                                         VSYNC,
  output logic                                         frame_start
);

  localparam int H_TOTAL   = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL   = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int CW        = $clog2(MAP_COLS);
  localparam int RW        = $clog2(MAP_ROWS);
  localparam int PW        = 3 * COLOR_W;
  // Map extent in pixels: x < MAP_W_PIX is the same test as (x>>TILE_LOG2) < MAP_COLS.
  localparam int MAP_W_PIX = MAP_COLS << TILE_LOG2;
  localparam int MAP_H_PIX = MAP_ROWS << TILE_LOG2;
  localparam logic HS_ON   = 1'(HS_POL);
  localparam logic VS_ON   = 1'(VS_POL);

  // Raster timing
  logic          pe_s;
  logic [HW-1:0] h_s;
  logic [VW-1:0] v_s;
  logic          vis_s;
  logic          hs_act_s;
  logic          vs_act_s;
  logic          frame_end_s;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .PIX_DIV  (PIX_DIV),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk       (clk_100mhz),
    .rst_n     (RSTN),
    .pe        (pe_s),
    .h         (h_s),
    .v         (v_s),
    .vis       (vis_s),
    .hs_act    (hs_act_s),
    .vs_act    (vs_act_s),
    .frame_end (frame_end_s)
  );

  // Stage-1 inputs decoded from the counters
  logic          in_map_s;
  logic [CW-1:0] col_s;
  logic [RW-1:0] row_s;
  logic          first_s;

  // Frame-start arming
  logic armed_r;

  // Stage 1
  logic                 s1_valid_r;
  logic [CW+RW-1:0]     map_addr_r;
  logic [TILE_LOG2-1:0] s1_tx_r;
  logic [TILE_LOG2-1:0] s1_ty_r;
  logic                 s1_vis_r;
  logic                 s1_in_map_r;
  logic                 s1_hs_r;
  logic                 s1_vs_r;
  logic                 s1_first_r;

  // Stage 2
  logic                 s2_valid_r;
  logic [TYPE_W-1:0]    tex_type_r;
  logic [TILE_LOG2-1:0] tex_x_r;
  logic [TILE_LOG2-1:0] tex_y_r;
  logic                 s2_vis_r;
  logic                 s2_in_map_r;
  logic                 s2_hs_r;
  logic                 s2_vs_r;
  logic                 s2_first_r;

  // Stage 3
  logic [PW-1:0] rgb_next_s;
  logic [PW-1:0] rgb_r;
  logic          hsync_r;
  logic          vsync_r;
  logic          frame_start_r;

  assign in_map_s = (int'(h_s) < MAP_W_PIX) && (int'(v_s) < MAP_H_PIX);
  assign col_s    = CW'(h_s >> TILE_LOG2);
  assign row_s    = RW'(v_s >> TILE_LOG2);
  // Only a (0,0) reached through a frame wrap is announced, so the frame
  // walked straight out of reset (possibly a cut-short one) never strobes.
  assign first_s  = armed_r && (h_s == '0) && (v_s == '0);

  // Arm the frame-start strobe once the raster has wrapped a full frame.
  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      armed_r <= 1'b0;
    end else if (frame_end_s) begin
      armed_r <= 1'b1;
    end
  end

  // Stage 1: map address (held outside the map), texel coords and flags.
  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      s1_valid_r  <= 1'b0;
      map_addr_r  <= '0;
      s1_tx_r     <= '0;
      s1_ty_r     <= '0;
      s1_vis_r    <= 1'b0;
      s1_in_map_r <= 1'b0;
      s1_hs_r     <= 1'b0;
      s1_vs_r     <= 1'b0;
      s1_first_r  <= 1'b0;
    end else if (pe_s) begin
      s1_valid_r  <= 1'b1;
      map_addr_r  <= in_map_s ? {col_s, row_s} : map_addr_r;
      s1_tx_r     <= h_s[TILE_LOG2-1:0];
      s1_ty_r     <= v_s[TILE_LOG2-1:0];
      s1_vis_r    <= vis_s;
      s1_in_map_r <= in_map_s;
      s1_hs_r     <= hs_act_s;
      s1_vs_r     <= vs_act_s;
      s1_first_r  <= first_s;
    end
  end

  // Stage 2: capture tile type from the map RAM and issue the texture request.
  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      s2_valid_r  <= 1'b0;
      tex_type_r  <= '0;
      tex_x_r     <= '0;
      tex_y_r     <= '0;
      s2_vis_r    <= 1'b0;
      s2_in_map_r <= 1'b0;
      s2_hs_r     <= 1'b0;
      s2_vs_r     <= 1'b0;
      s2_first_r  <= 1'b0;
    end else if (pe_s) begin
      s2_valid_r  <= s1_valid_r;
      tex_type_r  <= map_type;
      tex_x_r     <= s1_tx_r;
      tex_y_r     <= s1_ty_r;
      s2_vis_r    <= s1_vis_r;
      s2_in_map_r <= s1_in_map_r;
      s2_hs_r     <= s1_hs_r;
      s2_vs_r     <= s1_vs_r;
      s2_first_r  <= s1_first_r;
    end
  end

  // Colour select: black when blanked, border outside the map, else texel.
  always_comb begin
    rgb_next_s = '0;
    if (!s2_vis_r) begin
      rgb_next_s = '0;
    end else if (!s2_in_map_r) begin
      rgb_next_s = border_color;
    end else begin
      rgb_next_s = tex_pixel;
    end
  end

  // Stage 3: registered colour and polarity-adjusted sync outputs.
  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      rgb_r   <= '0;
      hsync_r <= ~HS_ON;
      vsync_r <= ~VS_ON;
    end else if (pe_s) begin
      rgb_r   <= rgb_next_s;
      hsync_r <= s2_hs_r ? HS_ON : ~HS_ON;
      vsync_r <= s2_vs_r ? VS_ON : ~VS_ON;
    end
  end

  // Frame strobe: high only in the clk after stage 3 loads pixel (0,0).
  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= pe_s && s2_valid_r && s2_first_r;
    end
  end

  assign map_addr    = map_addr_r;
  assign tex_type    = tex_type_r;
  assign tex_x       = tex_x_r;
  assign tex_y       = tex_y_r;
  assign Red         = rgb_r[PW-1:2*COLOR_W];
  assign Green       = rgb_r[2*COLOR_W-1:COLOR_W];
  assign Blue        = rgb_r[COLOR_W-1:0];
  assign HSYNC       = hsync_r;
  assign VSYNC       = vsync_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_tile_engine.sv
// tb_vga_tile_engine
//   Directed bench for vga_tile_engine using a shrunken raster so whole frames
//   fit in a short run: 24x16 slots (16x12 visible), 4-pixel tiles, a 3x2 tile
//   map (x<12, y<8), active-high HSYNC and active-low VSYNC.
//   Map RAM model : map_type  = {map_addr, 1}
//   Texture model : tex_pixel = {tex_type, tex_x, tex_y, tex_y, tex_x}
//   Slot s = v*24 + h. Stage 1/2/3 of slot s load on the posedge that is
//   4*(s+1) / 4*(s+2) / 4*(s+3) clocks after reset release.
module tb_vga_tile_engine;

  logic        clk_100mhz = 1'b0;
  logic        RSTN;
  logic [2:0]  map_addr;
  logic [3:0]  map_type;
  logic [3:0]  tex_type;
  logic [1:0]  tex_x;
  logic [1:0]  tex_y;
  logic [11:0] tex_pixel;
  logic [11:0] border_color;
  logic [3:0]  Red;
  logic [3:0]  Green;
  logic [3:0]  Blue;
  logic        HSYNC;
  logic        VSYNC;
  logic        frame_start;

  int cyc      = 0;
  int rel      = 0;
  int n_checks = 0;
  int n_errors = 0;
  int fs_q[$];

  vga_tile_engine #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (12), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL   (1),  .VS_POL (0), .PIX_DIV (4), .TILE_LOG2 (2),
    .MAP_COLS (3),  .MAP_ROWS (2), .TYPE_W (4), .COLOR_W (4)
  ) dut (
    .clk_100mhz   (clk_100mhz),
    .RSTN         (RSTN),
    .map_addr     (map_addr),
    .map_type     (map_type),
    .tex_type     (tex_type),
    .tex_x        (tex_x),
    .tex_y        (tex_y),
    .tex_pixel    (tex_pixel),
    .border_color (border_color),
    .Red          (Red),
    .Green        (Green),
    .Blue         (Blue),
    .HSYNC        (HSYNC),
    .VSYNC        (VSYNC),
    .frame_start  (frame_start)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  assign map_type  = {map_addr, 1'b1};
  assign tex_pixel = {tex_type, tex_x, tex_y, tex_y, tex_x};

  // Record the clock index of every frame_start sample seen high.
  always @(negedge clk_100mhz) begin
    if (frame_start === 1'b1) fs_q.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the k-th posedge following release.
  task automatic goto_clk(input int k);
    while (cyc < rel + k) begin
      @(posedge clk_100mhz);
      #2;
    end
  endtask

  task automatic probe_out(input int s, input logic [11:0] rgb, input logic hs, input logic vs);
    goto_clk(4 * (s + 3));
    check_eq($sformatf("rgb@%0d", s), {Red, Green, Blue}, rgb);
    check_eq($sformatf("sync@%0d", s), {HSYNC, VSYNC}, {hs, vs});
  endtask

  task automatic probe_full(input int s, input logic [2:0] addr, input logic [3:0] typ,
                            input logic [1:0] tx, input logic [1:0] ty,
                            input logic [11:0] rgb, input logic hs, input logic vs);
    goto_clk(4 * (s + 1));
    check_eq($sformatf("addr@%0d", s), map_addr, addr);
    goto_clk(4 * (s + 2));
    check_eq($sformatf("tex@%0d", s), {tex_type, tex_x, tex_y}, {typ, tx, ty});
    probe_out(s, rgb, hs, vs);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_rgb"}, {Red, Green, Blue}, 12'h000);
    check_eq({tag, "_sync"}, {HSYNC, VSYNC}, 2'b01);
    check_eq({tag, "_fs"}, frame_start, 1'b0);
    check_eq({tag, "_addr_tex"}, {map_addr, tex_type, tex_x, tex_y}, 11'd0);
  endtask

  initial begin
    RSTN         = 1'b0;
    border_color = 12'hA5C;
    repeat (3) @(posedge clk_100mhz);
    #2;
    check_reset_values("por");

    @(negedge clk_100mhz);
    RSTN = 1'b1;
    rel  = cyc;

    // Line 0: map interior, last in-map column, border, blanking, HS edges.
    probe_full(0,  3'd0, 4'h1, 2'd0, 2'd0, 12'h100, 1'b0, 1'b1);
    probe_full(11, 3'd4, 4'h9, 2'd3, 2'd0, 12'h9C3, 1'b0, 1'b1);
    probe_out(12, 12'hA5C, 1'b0, 1'b1);
    probe_out(15, 12'hA5C, 1'b0, 1'b1);
    probe_out(16, 12'h000, 1'b0, 1'b1);
    probe_out(18, 12'h000, 1'b1, 1'b1);
    probe_out(20, 12'h000, 1'b1, 1'b1);
    probe_out(21, 12'h000, 1'b0, 1'b1);

    // Line 6: tile (1,1), border right of the map with held address, HS pulse.
    probe_full(149, 3'd3, 4'h7, 2'd1, 2'd2, 12'h769, 1'b0, 1'b1);
    probe_full(157, 3'd5, 4'hB, 2'd1, 2'd2, 12'hA5C, 1'b0, 1'b1);
    probe_full(163, 3'd5, 4'hB, 2'd3, 2'd2, 12'h000, 1'b1, 1'b1);

    // Below the map, vertical blanking and VS window edges.
    probe_full(219, 3'd5, 4'hB, 2'd3, 2'd1, 12'hA5C, 1'b0, 1'b1);
    probe_out(288, 12'h000, 1'b0, 1'b1);
    probe_full(314, 3'd5, 4'hB, 2'd2, 2'd1, 12'h000, 1'b0, 1'b0);
    probe_out(360, 12'h000, 1'b0, 1'b1);

    // Second frame, pixel (1,0): address returns to tile (0,0).
    probe_full(385, 3'd0, 4'h1, 2'd1, 2'd0, 12'h141, 1'b0, 1'b1);

    // Frame strobes: first at 4*(384+3) clks, then one per 1536-clk frame.
    goto_clk(3100);
    check_eq("fs_count", fs_q.size(), 2);
    check_eq("fs_first", (fs_q.size() > 0) ? fs_q[0] - rel : -1, 1548);
    check_eq("fs_period", (fs_q.size() > 1) ? fs_q[1] - fs_q[0] : -1, 1536);

    // Third frame, (19,13): both syncs active, then an asynchronous reset.
    probe_full(1099, 3'd5, 4'hB, 2'd3, 2'd1, 12'h000, 1'b1, 1'b0);
    #1;
    RSTN = 1'b0;
    #1;
    check_reset_values("mid");

    repeat (2) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    RSTN = 1'b1;
    rel  = cyc;
    fs_q.delete();

    // Restart from (0,0): first pe lands 4 clks after release.
    goto_clk(11);
    check_eq("restart_tx_pre", tex_x, 2'd0);
    goto_clk(12);
    check_eq("restart_tx", tex_x, 2'd1);
    check_eq("restart_rgb", {Red, Green, Blue}, 12'h100);
    goto_clk(1547);
    check_eq("restart_no_early_fs", fs_q.size(), 0);
    goto_clk(1600);
    check_eq("restart_fs_count", fs_q.size(), 1);
    check_eq("restart_fs_first", (fs_q.size() > 0) ? fs_q[0] - rel : -1, 1548);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
